// File: rtl/sw_pkg.sv
// rtl/sw_pkg.sv - base codes and loader FSM state type shared with the SW core
package sw_pkg;

  localparam logic [1:0] BASE_A = 2'b00;
  localparam logic [1:0] BASE_C = 2'b01;
  localparam logic [1:0] BASE_G = 2'b10;
  localparam logic [1:0] BASE_T = 2'b11;

  typedef enum logic [1:0] {
    ST_LOAD   = 2'd0,
    ST_STREAM = 2'd1,
    ST_WAIT   = 2'd2
  } sw_state_t;

endpackage

// File: rtl/sw_base_enc.sv
// rtl/sw_base_enc.sv - ASCII nucleotide to 2-bit code, case-insensitive
module sw_base_enc
  import sw_pkg::*;
(
  input  logic [7:0] i_char,
  output logic [1:0] o_code,
  output logic       o_ok
);

  always_comb begin
    o_code = BASE_A;
    o_ok   = 1'b1;
    case (i_char)
      8'h41, 8'h61: o_code = BASE_A;
      8'h43, 8'h63: o_code = BASE_C;
      8'h47, 8'h67: o_code = BASE_G;
      8'h54, 8'h74: o_code = BASE_T;
      default:      o_ok   = 1'b0;
    endcase
  end

endmodule

// File: rtl/sw_seq_loader.sv
// rtl/sw_seq_loader.sv - buffers reference/query bases and streams them to the SW core
module sw_seq_loader
  import sw_pkg::*;
#(
  parameter int WIDTH_POS_REF   = 7,
  parameter int WIDTH_POS_QUERY = 6
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       in_sel,
  input  logic [7:0] in_data,
  input  logic       sw_finish,
  output logic       valid,
  output logic [1:0] data_ref,
  output logic [1:0] data_query,
  output logic       busy,
  output logic       err_char
);

  localparam int REF_LEN = 2 ** WIDTH_POS_REF;
  localparam int QRY_LEN = 2 ** WIDTH_POS_QUERY;
  localparam logic [WIDTH_POS_REF:0]   REF_FULL = (WIDTH_POS_REF + 1)'(REF_LEN);
  localparam logic [WIDTH_POS_REF:0]   REF_LAST = (WIDTH_POS_REF + 1)'(REF_LEN - 1);
  localparam logic [WIDTH_POS_REF:0]   REF_ONE  = (WIDTH_POS_REF + 1)'(1);
  localparam logic [WIDTH_POS_REF:0]   QRY_BEAT = (WIDTH_POS_REF + 1)'(QRY_LEN);
  localparam logic [WIDTH_POS_QUERY:0] QRY_FULL = (WIDTH_POS_QUERY + 1)'(QRY_LEN);
  localparam logic [WIDTH_POS_QUERY:0] QRY_LAST = (WIDTH_POS_QUERY + 1)'(QRY_LEN - 1);
  localparam logic [WIDTH_POS_QUERY:0] QRY_ONE  = (WIDTH_POS_QUERY + 1)'(1);

  sw_state_t                r_state;
  logic [WIDTH_POS_REF:0]   r_ref_cnt;
  logic [WIDTH_POS_QUERY:0] r_qry_cnt;
  logic [WIDTH_POS_REF:0]   r_beat;
  logic [1:0]               r_ref_mem [REF_LEN];
  logic [1:0]               r_qry_mem [QRY_LEN];

  logic [1:0] w_code;
  logic       w_ok;
  logic       w_acc;
  logic       w_wr_ref;
  logic       w_wr_qry;
  logic       w_ref_done;
  logic       w_qry_done;
  logic       w_has_qry;

  sw_base_enc u_enc (
    .i_char (in_data),
    .o_code (w_code),
    .o_ok   (w_ok)
  );

  always_comb begin
    in_ready = 1'b0;
    if (r_state == ST_LOAD)
      in_ready = in_sel ? (r_qry_cnt < QRY_FULL) : (r_ref_cnt < REF_FULL);
  end

  assign w_acc     = in_valid & in_ready;
  assign w_wr_ref  = w_acc & w_ok & ~in_sel;
  assign w_wr_qry  = w_acc & w_ok & in_sel;
  assign w_has_qry = (r_beat < QRY_BEAT);
  assign busy      = (r_state != ST_LOAD);

  // Look ahead one write so beat 0 is registered on the same edge as the last byte.
  assign w_ref_done = (r_ref_cnt == REF_FULL) | (w_wr_ref & (r_ref_cnt == REF_LAST));
  assign w_qry_done = (r_qry_cnt == QRY_FULL) | (w_wr_qry & (r_qry_cnt == QRY_LAST));

  always_ff @(posedge clk) begin
    if (w_wr_ref) r_ref_mem[r_ref_cnt[WIDTH_POS_REF-1:0]] <= w_code;
    if (w_wr_qry) r_qry_mem[r_qry_cnt[WIDTH_POS_QUERY-1:0]] <= w_code;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_LOAD;
      r_ref_cnt  <= '0;
      r_qry_cnt  <= '0;
      r_beat     <= '0;
      valid      <= 1'b0;
      data_ref   <= BASE_A;
      data_query <= BASE_A;
      err_char   <= 1'b0;
    end else begin
      err_char   <= w_acc & ~w_ok;
      valid      <= 1'b0;
      data_ref   <= BASE_A;
      data_query <= BASE_A;
      case (r_state)
        ST_LOAD: begin
          if (w_wr_ref) r_ref_cnt <= r_ref_cnt + REF_ONE;
          if (w_wr_qry) r_qry_cnt <= r_qry_cnt + QRY_ONE;
          if (w_ref_done && w_qry_done) begin
            r_state    <= ST_STREAM;
            valid      <= 1'b1;
            data_ref   <= r_ref_mem[0];
            data_query <= r_qry_mem[0];
            r_beat     <= REF_ONE;
          end
        end
        ST_STREAM: begin
          if (r_beat == REF_FULL) begin
            r_state <= ST_WAIT;
          end else begin
            valid      <= 1'b1;
            data_ref   <= r_ref_mem[r_beat[WIDTH_POS_REF-1:0]];
            data_query <= w_has_qry ? r_qry_mem[r_beat[WIDTH_POS_QUERY-1:0]] : BASE_A;
            r_beat     <= r_beat + REF_ONE;
          end
        end
        ST_WAIT: begin
          if (sw_finish) begin
            r_state   <= ST_LOAD;
            r_ref_cnt <= '0;
            r_qry_cnt <= '0;
            r_beat    <= '0;
          end
        end
        default: r_state <= ST_LOAD;
      endcase
    end
  end

endmodule
